mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
- REQ-001: Parameter ADDR_W, default 32, address width of requester and memory ports.
- REQ-002: Parameter DATA_W, default 32, read/write data width.
- REQ-003: One clock; reset is synchronous and active-high; ports clk_in and rst_in.
- REQ-004: clk_in  input  1  system clock; all state SHALL update on its rising edge.
- REQ-005: rst_in  input  1  synchronous active-high reset.
- REQ-006: reqN_addr_in  input  ADDR_W  requester N (N=0,1) address; sampled only on a dispatch pulse.
- REQ-007: reqN_width_in  input  2  requester N access width, mem::BYTE/WORD/DWORD.
- REQ-008: reqN_write_data_in  input  DATA_W  requester N store data.
- REQ-009: reqN_dispatch_read_in / reqN_dispatch_write_in  input  1 each  single-cycle request pulses.
- REQ-010: reqN_read_data_out  output  DATA_W  registered load result for requester N.
- REQ-011: reqN_busy_out  output  1  requester N has a request pending or in flight.
- REQ-012: mem_addr_out, mem_width_out, mem_write_data_out  output  ADDR_W/2/DATA_W  registered downstream request fields.
- REQ-013: mem_dispatch_read_out / mem_dispatch_write_out  output  1 each  downstream single-cycle pulses.
- REQ-014: mem_read_data_in  input  DATA_W, mem_busy_in  input  1  downstream load data and busy.
- REQ-015: grant_out  output  1  index of the requester owning the current or last transaction.
- REQ-016: protocol_err_out  output  1  sticky requester protocol-violation flag.

Function
- REQ-017: A dispatch pulse on port N while reqN_busy_out is low SHALL latch addr, width, write_data and direction into that port's pending slot; reqN_busy_out SHALL be high from the next cycle.
- REQ-018: FSM states IDLE, ISSUE, ACK, WAIT, COMPLETE; IDLE->ISSUE when any slot is pending and mem_busy_in is low.
- REQ-019: ISSUE: exactly one mem_dispatch_*_out high for one cycle with the granted slot's fields; then ACK (one cycle, busy ignored); then WAIT until mem_busy_in is low; then COMPLETE; then IDLE.
- REQ-020: COMPLETE SHALL capture mem_read_data_in into the granted port's read_data register (loads only) and clear its slot; reqN_busy_out SHALL go low in the following cycle, with read data valid in that same cycle.
- REQ-021: Minimum request-pulse-to-downstream-dispatch latency SHALL be 2 cycles.
- REQ-022: Arbitration SHALL be round-robin: on contention, the port not granted last wins; a single pending port wins immediately.
- REQ-023: Simultaneous pulses on both ports SHALL latch both slots and serve them back-to-back.
- REQ-024: A pulse on a port whose busy is high, or read and write pulsed together, SHALL be ignored and set protocol_err_out.
- REQ-025: reqN_read_data_out SHALL hold its value until the next load completion on that port; stores SHALL not alter it.
- REQ-026: Downstream fields SHALL hold their last value outside ISSUE; dispatch outputs SHALL be low outside ISSUE.

Reset
- REQ-027: rst_in SHALL clear both slots, all busy and dispatch outputs, protocol_err_out, read_data registers and grant_out to 0, and force IDLE, including mid-transaction; an in-flight downstream access SHALL be abandoned without write-back.

Configuration
- REQ-028: With MEM_ARB_FIXED_PRIORITY_EN defined, port 0 SHALL always win contention; without it, REQ-022 round-robin applies.

Structure
- REQ-029: The arbiter state enum and a pending-slot struct (addr, width, data, is_write) SHALL live in a shared package, mem_arb_pkg; the width encoding SHALL reuse the existing mem package.
- REQ-030: The per-port slot SHALL be a sub-module, mem_arb_slot, instantiated twice.

Verification
- REQ-031: Port 0 load of 0x100, memory busy for 3 cycles returning 0xDEADBEEF -> single dispatch 2 cycles after the pulse, req0_read_data_out=0xDEADBEEF, req0_busy_out low after COMPLETE.
- REQ-032: Both ports pulse together (store 0x55 to 0x20 on port 0, load 0x40 on port 1) -> port 0 first, port 1 immediately after, grant_out 0 then 1.
- REQ-033: Repeated contention, 4 rounds -> grants alternate 0,1,0,1; with MEM_ARB_FIXED_PRIORITY_EN -> grants 0,0,0,0 until port 0 goes quiet.
- REQ-034: Port 1 pulses again while busy -> pulse ignored, protocol_err_out=1, and exactly one downstream transaction occurs.
- REQ-035: rst_in asserted during WAIT -> next cycle all outputs 0, state IDLE, no further dispatch.
- REQ-036: Store to 0x8 with width BYTE -> mem_width_out=BYTE, mem_write_data_out matches, req0_read_data_out unchanged.

Source files
------------

// File: rtl/mem.sv
// Memory-subsystem shared definitions: access-width encoding used by every
// block that talks to the memory bus.
package mem;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    WORD  = 2'd1,
    DWORD = 2'd2
  } width_t;

endpackage

// File: rtl/mem_arb_pkg.sv
// Types shared by the two-port memory bus arbiter: FSM state enum and the
// pending-request slot record.
package mem_arb_pkg;

  // Slot fields are sized for the widest supported bus; ports truncate on use.
  localparam int SLOT_ADDR_MAX = 64;
  localparam int SLOT_DATA_MAX = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_ACK      = 3'd2,
    ST_WAIT     = 3'd3,
    ST_COMPLETE = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic [SLOT_ADDR_MAX-1:0] addr;
    mem::width_t              width;
    logic [SLOT_DATA_MAX-1:0] data;
    logic                     is_write;
  } slot_t;

endpackage

// File: rtl/mem_arb_slot.sv
// One requester's pending-request slot: latches a legal dispatch pulse while
// empty and flags pulses that arrive while occupied or with both directions set.
module mem_arb_slot
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dispatch_read,
  input  logic              i_dispatch_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_width,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  output logic              o_valid,
  output slot_t             o_slot,
  output logic              o_proto_err
);

  logic  w_any;
  logic  w_accept;
  logic  r_valid;
  slot_t r_slot;

  assign w_any       = i_dispatch_read | i_dispatch_write;
  assign w_accept    = (i_dispatch_read ^ i_dispatch_write) & ~r_valid;
  assign o_proto_err = w_any & (r_valid | (i_dispatch_read & i_dispatch_write));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  // Payload is only meaningful while r_valid, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_slot.addr     <= SLOT_ADDR_MAX'(i_addr);
      r_slot.width    <= mem::width_t'(i_width);
      r_slot.data     <= SLOT_DATA_MAX'(i_data);
      r_slot.is_write <= i_dispatch_write;
    end
  end

  assign o_valid = r_valid;
  assign o_slot  = r_slot;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: one outstanding downstream access at a time,
// round-robin on contention, or port 0 always first with MEM_ARB_FIXED_PRIORITY_EN.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] req0_addr_in,
  input  logic [1:0]        req0_width_in,
  input  logic [DATA_W-1:0] req0_write_data_in,
  input  logic              req0_dispatch_read_in,
  input  logic              req0_dispatch_write_in,
  output logic [DATA_W-1:0] req0_read_data_out,
  output logic              req0_busy_out,
  input  logic [ADDR_W-1:0] req1_addr_in,
  input  logic [1:0]        req1_width_in,
  input  logic [DATA_W-1:0] req1_write_data_in,
  input  logic              req1_dispatch_read_in,
  input  logic              req1_dispatch_write_in,
  output logic [DATA_W-1:0] req1_read_data_out,
  output logic              req1_busy_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [1:0]        mem_width_out,
  output logic [DATA_W-1:0] mem_write_data_out,
  output logic              mem_dispatch_read_out,
  output logic              mem_dispatch_write_out,
  input  logic [DATA_W-1:0] mem_read_data_in,
  input  logic              mem_busy_in,
  output logic              grant_out,
  output logic              protocol_err_out
);

  arb_state_t        r_state;
  logic              r_grant;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [1:0]        r_mem_width;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_disp_rd;
  logic              r_disp_wr;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_err;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
  logic              r_prio;
`endif

  logic  w_valid0;
  logic  w_valid1;
  logic  w_err0;
  logic  w_err1;
  logic  w_clr0;
  logic  w_clr1;
  logic  w_pick;
  slot_t w_slot0;
  slot_t w_slot1;
  slot_t w_sel;

  assign w_clr0 = (r_state == ST_COMPLETE) & ~r_grant;
  assign w_clr1 = (r_state == ST_COMPLETE) &  r_grant;

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .i_clk           (clk_in),
    .i_rst           (rst_in),
    .i_dispatch_read (req0_dispatch_read_in),
    .i_dispatch_write(req0_dispatch_write_in),
    .i_addr          (req0_addr_in),
    .i_width         (req0_width_in),
    .i_data          (req0_write_data_in),
    .i_clear         (w_clr0),
    .o_valid         (w_valid0),
    .o_slot          (w_slot0),
    .o_proto_err     (w_err0)
  );

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .i_clk           (clk_in),
    .i_rst           (rst_in),
    .i_dispatch_read (req1_dispatch_read_in),
    .i_dispatch_write(req1_dispatch_write_in),
    .i_addr          (req1_addr_in),
    .i_width         (req1_width_in),
    .i_data          (req1_write_data_in),
    .i_clear         (w_clr1),
    .o_valid         (w_valid1),
    .o_slot          (w_slot1),
    .o_proto_err     (w_err1)
  );

  always_comb begin
    w_pick = w_valid1;
    if (w_valid0 && w_valid1) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      w_pick = 1'b0;
`else
      w_pick = r_prio;
`endif
    end
  end

  assign w_sel = w_pick ? w_slot1 : w_slot0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_grant     <= 1'b0;
      r_is_write  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_width <= '0;
      r_mem_wdata <= '0;
      r_disp_rd   <= 1'b0;
      r_disp_wr   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_err       <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      r_prio      <= 1'b0;
`endif
    end else begin
      r_err <= r_err | w_err0 | w_err1;
      case (r_state)
        ST_IDLE: begin
          if ((w_valid0 || w_valid1) && !mem_busy_in) begin
            r_grant     <= w_pick;
            r_is_write  <= w_sel.is_write;
            r_mem_addr  <= ADDR_W'(w_sel.addr);
            r_mem_width <= w_sel.width;
            r_mem_wdata <= DATA_W'(w_sel.data);
            r_disp_rd   <= ~w_sel.is_write;
            r_disp_wr   <= w_sel.is_write;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            r_prio      <= ~w_pick;
`endif
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_disp_rd <= 1'b0;
          r_disp_wr <= 1'b0;
          r_state   <= ST_ACK;
        end
        // Downstream busy is not valid until one cycle after the dispatch.
        ST_ACK: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (!mem_busy_in) r_state <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          if (!r_is_write) begin
            if (r_grant) r_rdata1 <= mem_read_data_in;
            else         r_rdata0 <= mem_read_data_in;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req0_read_data_out     = r_rdata0;
  assign req1_read_data_out     = r_rdata1;
  assign req0_busy_out          = w_valid0;
  assign req1_busy_out          = w_valid1;
  assign mem_addr_out           = r_mem_addr;
  assign mem_width_out          = r_mem_width;
  assign mem_write_data_out     = r_mem_wdata;
  assign mem_dispatch_read_out  = r_disp_rd;
  assign mem_dispatch_write_out = r_disp_wr;
  assign grant_out              = r_grant;
  assign protocol_err_out       = r_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: timestamp-based transaction model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_bus_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] req0_addr_in, req1_addr_in;
  logic [1:0]  req0_width_in, req1_width_in;
  logic [31:0] req0_write_data_in, req1_write_data_in;
  logic        req0_dispatch_read_in, req0_dispatch_write_in;
  logic        req1_dispatch_read_in, req1_dispatch_write_in;
  logic [31:0] req0_read_data_out, req1_read_data_out;
  logic        req0_busy_out, req1_busy_out;
  logic [31:0] mem_addr_out;
  logic [1:0]  mem_width_out;
  logic [31:0] mem_write_data_out;
  logic        mem_dispatch_read_out, mem_dispatch_write_out;
  logic [31:0] mem_read_data_in = '0;
  logic        mem_busy_in;
  logic        grant_out, protocol_err_out;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req0_addr_in(req0_addr_in), .req0_width_in(req0_width_in),
    .req0_write_data_in(req0_write_data_in),
    .req0_dispatch_read_in(req0_dispatch_read_in), .req0_dispatch_write_in(req0_dispatch_write_in),
    .req0_read_data_out(req0_read_data_out), .req0_busy_out(req0_busy_out),
    .req1_addr_in(req1_addr_in), .req1_width_in(req1_width_in),
    .req1_write_data_in(req1_write_data_in),
    .req1_dispatch_read_in(req1_dispatch_read_in), .req1_dispatch_write_in(req1_dispatch_write_in),
    .req1_read_data_out(req1_read_data_out), .req1_busy_out(req1_busy_out),
    .mem_addr_out(mem_addr_out), .mem_width_out(mem_width_out),
    .mem_write_data_out(mem_write_data_out),
    .mem_dispatch_read_out(mem_dispatch_read_out), .mem_dispatch_write_out(mem_dispatch_write_out),
    .mem_read_data_in(mem_read_data_in), .mem_busy_in(mem_busy_in),
    .grant_out(grant_out), .protocol_err_out(protocol_err_out)
  );

  initial forever #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: no response within cycle budget (t=%0t)", nm, $time);
  endtask

  // Downstream memory responder.
  int          mem_cnt = 0;
  int          mem_lat = 0;
  int          n_disp  = 0;
  logic [31:0] mem_rd_val = '0;
  bit          rand_mode = 1'b0, rand_busy = 1'b0, force_busy = 1'b0;

  assign mem_busy_in = force_busy || (mem_cnt > 0) || rand_busy;

  always @(negedge clk_in) begin
    if (mem_dispatch_read_out || mem_dispatch_write_out) begin
      n_disp++;
      mem_cnt          = rand_mode ? int'($urandom_range(0, 4)) : mem_lat;
      mem_read_data_in = rand_mode ? $urandom : mem_rd_val;
    end else if (mem_cnt > 0) begin
      mem_cnt--;
    end
    rand_busy = rand_mode && (mem_cnt == 0) && ($urandom_range(0, 5) == 0);
  end

  // Reference model: slots, a single server with timestamps, round-robin pointer.
  int unsigned m_e = 0, m_disp_e = 0, m_cmp_e = 0, m_next_dec = 0;
  bit          m_pend [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [1:0]  m_w    [2];
  bit          m_wr   [2];
  logic [31:0] m_rdata[2];
  bit          m_infl = 0, m_err = 0, m_grant = 0, m_prio = 0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [1:0]  e_w = '0;
  bit          e_drd = 0, e_dwr = 0;

  always @(posedge clk_in) begin : model
    bit old_p [2];
    bit rd, wr;
    int pk;
    m_e++;
    if (rst_in) begin
      for (int p = 0; p < 2; p++) begin m_pend[p] = 0; m_rdata[p] = '0; end
      m_infl = 0; m_err = 0; m_grant = 0; m_prio = 0;
      e_addr = '0; e_wdata = '0; e_w = '0; e_drd = 0; e_dwr = 0;
      m_next_dec = m_e + 1;
    end else begin
      old_p = m_pend;
      e_drd = 0; e_dwr = 0;
      if (m_infl) begin
        if (m_cmp_e == 0) begin
          if (m_e >= m_disp_e + 3 && !mem_busy_in) m_cmp_e = m_e + 1;
        end else if (m_e == m_cmp_e) begin
          if (!m_wr[m_grant]) m_rdata[m_grant] = mem_read_data_in;
          m_pend[m_grant] = 0;
          m_infl = 0;
          m_next_dec = m_e + 1;
        end
      end else if (m_e >= m_next_dec && (old_p[0] || old_p[1]) && !mem_busy_in) begin
        if (old_p[0] && old_p[1]) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
          pk = 0;
`else
          pk = m_prio ? 1 : 0;
`endif
        end else pk = old_p[1] ? 1 : 0;
        m_grant = (pk == 1); m_prio = (pk == 0);
        e_addr = m_addr[pk]; e_w = m_w[pk]; e_wdata = m_data[pk];
        e_drd = !m_wr[pk]; e_dwr = m_wr[pk];
        m_infl = 1; m_disp_e = m_e; m_cmp_e = 0;
      end
      for (int p = 0; p < 2; p++) begin
        rd = (p == 0) ? req0_dispatch_read_in  : req1_dispatch_read_in;
        wr = (p == 0) ? req0_dispatch_write_in : req1_dispatch_write_in;
        if (rd || wr) begin
          if (old_p[p] || (rd && wr)) m_err = 1;
          else begin
            m_pend[p] = 1; m_wr[p] = wr;
            m_addr[p] = (p == 0) ? req0_addr_in : req1_addr_in;
            m_w[p]    = (p == 0) ? req0_width_in : req1_width_in;
            m_data[p] = (p == 0) ? req0_write_data_in : req1_write_data_in;
          end
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("busy0", req0_busy_out, m_pend[0]);
      chk("busy1", req1_busy_out, m_pend[1]);
      chk("rdata0", req0_read_data_out, m_rdata[0]);
      chk("rdata1", req1_read_data_out, m_rdata[1]);
      chk("mem_addr", mem_addr_out, e_addr);
      chk("mem_width", mem_width_out, e_w);
      chk("mem_wdata", mem_write_data_out, e_wdata);
      chk("disp_rd", mem_dispatch_read_out, e_drd);
      chk("disp_wr", mem_dispatch_write_out, e_dwr);
      chk("grant", grant_out, m_grant);
      chk("proto_err", protocol_err_out, m_err);
    end
  end

  task automatic set_req(input int p, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [1:0] w, input logic [31:0] d);
    if (p == 0) begin
      req0_dispatch_read_in = rd; req0_dispatch_write_in = wr;
      req0_addr_in = a; req0_width_in = w; req0_write_data_in = d;
    end else begin
      req1_dispatch_read_in = rd; req1_dispatch_write_in = wr;
      req1_addr_in = a; req1_width_in = w; req1_write_data_in = d;
    end
  endtask

  task automatic clr_req();
    req0_dispatch_read_in = 0; req0_dispatch_write_in = 0;
    req1_dispatch_read_in = 0; req1_dispatch_write_in = 0;
  endtask

  task automatic do_reset();
    rst_in = 1;
    @(negedge clk_in);
    rst_in = 0;
  endtask

  task automatic wait_disp(input string nm, output bit g);
    bit found = 0;
    g = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk_in);
      if (mem_dispatch_read_out || mem_dispatch_write_out) begin found = 1; g = grant_out; end
    end
    if (!found) timeout(nm);
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_in);
      done = !req0_busy_out && !req1_busy_out;
    end
    if (!done) timeout(nm);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit g, ok;
    bit exp_g;
    int n0, k;
    clr_req();
    set_req(0, 0, 0, '0, 2'd0, '0); set_req(1, 0, 0, '0, 2'd0, '0);
    rst_in = 1;
    repeat (3) @(negedge clk_in);
    chk_en = 1;
    chk("rst_busy0", req0_busy_out, 0);
    chk("rst_busy1", req1_busy_out, 0);
    chk("rst_grant", grant_out, 0);
    chk("rst_err", protocol_err_out, 0);
    chk("rst_rdata0", req0_read_data_out, 0);

    // Single port-0 load, memory busy 3 cycles.
    rst_in = 0; mem_lat = 3; mem_rd_val = 32'hDEADBEEF;
    n0 = n_disp;
    set_req(0, 1, 0, 32'h100, 2'd1, '0);
    @(negedge clk_in); clr_req();
    chk("load_busy", req0_busy_out, 1);
    @(negedge clk_in);
    chk("load_latency_disp", mem_dispatch_read_out, 1);
    chk("load_addr", mem_addr_out, 32'h100);
    wait_idle("load_done");
    chk("load_rdata", req0_read_data_out, 32'hDEADBEEF);
    chk("load_ndisp", n_disp - n0, 1);

    // Byte store leaves load data untouched.
    set_req(0, 0, 1, 32'h8, 2'd0, 32'hA5);
    @(negedge clk_in); clr_req();
    wait_disp("store_disp", g);
    chk("store_wr", mem_dispatch_write_out, 1);
    chk("store_width", mem_width_out, 2'd0);
    chk("store_wdata", mem_write_data_out, 32'hA5);
    wait_idle("store_done");
    chk("store_rdata_keep", req0_read_data_out, 32'hDEADBEEF);

    // Simultaneous pulses from reset.
    do_reset(); mem_rd_val = 32'hCAFE0001;
    set_req(0, 0, 1, 32'h20, 2'd2, 32'h55);
    set_req(1, 1, 0, 32'h40, 2'd2, '0);
    @(negedge clk_in); clr_req();
    wait_disp("both_first", g);
    chk("both_first_grant", g, 0);
    chk("both_first_addr", mem_addr_out, 32'h20);
    chk("both_first_wdata", mem_write_data_out, 32'h55);
    wait_disp("both_second", g);
    chk("both_second_grant", g, 1);
    chk("both_second_addr", mem_addr_out, 32'h40);
    wait_idle("both_done");
    chk("both_rdata1", req1_read_data_out, 32'hCAFE0001);
    chk("both_rdata0", req0_read_data_out, 0);

    // Repeated contention: both slots pending at every decision.
    do_reset(); force_busy = 1;
    set_req(0, 1, 0, 32'h1000, 2'd2, '0); set_req(1, 1, 0, 32'h2000, 2'd2, '0);
    @(negedge clk_in); clr_req(); force_busy = 0;
    for (int r = 0; r < 4; r++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      exp_g = 0;
`else
      exp_g = (r % 2 == 1);
`endif
      wait_disp("rr_disp", g);
      chk("rr_grant", g, exp_g);
      if (r < 3) begin
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
          @(negedge clk_in);
          ok = g ? !req1_busy_out : !req0_busy_out;
        end
        if (!ok) timeout("rr_release");
        force_busy = 1;
        set_req(g ? 1 : 0, 1, 0, 32'h3000 + r, 2'd2, '0);
        @(negedge clk_in); clr_req(); force_busy = 0;
      end
    end
    wait_idle("rr_done");

    // Pulse while busy is ignored and flagged.
    do_reset(); mem_lat = 2; mem_rd_val = 32'h0BADF00D;
    n0 = n_disp;
    set_req(1, 1, 0, 32'h80, 2'd2, '0);
    @(negedge clk_in);
    set_req(1, 1, 0, 32'h90, 2'd2, '0);
    @(negedge clk_in); clr_req();
    chk("proto_err_set", protocol_err_out, 1);
    repeat (30) @(negedge clk_in);
    chk("proto_ndisp", n_disp - n0, 1);
    chk("proto_rdata1", req1_read_data_out, 32'h0BADF00D);

    // Reset in the middle of a long downstream wait.
    do_reset(); mem_lat = 8;
    set_req(0, 1, 0, 32'h300, 2'd2, '0);
    @(negedge clk_in); clr_req();
    wait_disp("midrst_disp", g);
    repeat (3) @(negedge clk_in);
    rst_in = 1;
    @(negedge clk_in);
    rst_in = 0;
    chk("midrst_busy0", req0_busy_out, 0);
    chk("midrst_disp", mem_dispatch_read_out, 0);
    chk("midrst_addr", mem_addr_out, 0);
    chk("midrst_rdata0", req0_read_data_out, 0);
    n0 = n_disp;
    repeat (15) @(negedge clk_in);
    chk("midrst_no_disp", n_disp - n0, 0);

    // Randomized traffic.
    do_reset(); rand_mode = 1;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk_in);
      clr_req();
      rst_in = ($urandom_range(0, 149) == 0);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          if (((p == 0) ? req0_busy_out : req1_busy_out) && $urandom_range(0, 9) != 0) continue;
          k = $urandom_range(0, 15);
          set_req(p, (k == 0) || (k % 2 == 1), (k == 0) || (k % 2 == 0),
                  $urandom, 2'($urandom_range(0, 2)), $urandom);
        end
      end
    end
    @(negedge clk_in);
    clr_req(); rst_in = 0; rand_mode = 0;
    wait_idle("rand_drain");
    @(negedge clk_in);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
